ram_port_arbiter: RTL

Shares one single-port synchronous block RAM between a write requester and a read requester. The write requester is the UART byte packer that assembles received bytes into 16-bit words. The read requester is a consumer such as the UART transmit readback or a display fetch. The block sits between both requesters and the BRAM, serialises accesses with a req/ack handshake and returns read data with a valid strobe.

---
 rtl/ram_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises a writer and a reader onto one single-port synchronous BRAM.
// Define RAM_ARB_ROUND_ROBIN_EN for alternating grants under contention; default is writer priority.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ack_o,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_ack_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_din_o,
    input  logic [DW-1:0] ram_dout_i
);
    typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          grant_wr;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic          last_wr_q, last_wr_d;
    assign grant_wr = wr_req_i && (!rd_req_i || !last_wr_q);
`else
    assign grant_wr = wr_req_i;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_wr_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_wr_q  <= last_wr_d;
`endif
        end
    end
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_wr_d  = last_wr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d = WR;
                    addr_d  = wr_addr_i;
                    din_d   = wr_data_i;
                end else if (rd_req_i) begin
                    state_d = RD;
                    addr_d  = rd_addr_i;
                end
`ifdef RAM_ARB_ROUND_ROBIN_EN
                if (wr_req_i || rd_req_i) last_wr_d = grant_wr;
`endif
            end
            WR:      state_d = IDLE;
            RD:      state_d = RD_WAIT;
            default: begin
                state_d    = IDLE;
                rd_data_d  = ram_dout_i;
                rd_valid_d = 1'b1;
            end
        endcase
    end
    // RAM side and acks decode purely from registered state and operands
    assign ram_en_o   = state_q == WR || state_q == RD;
    assign ram_we_o   = state_q == WR;
    assign ram_addr_o = addr_q;
    assign ram_din_o  = din_q;
    assign wr_ack_o   = state_q == WR;
    assign rd_ack_o   = state_q == RD;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
endmodule
